lsu_reservation_station: RTL

// - Parametrised load/store reservation station for the out-of-order core; sits between dispatch and the load/store buffers.
// - Holds DEPTH memory ops and snoops the CDB for missing operands.
// - Issues the oldest ready op with a computed effective address to a load port or a store port over valid/ready handshakes.
// - Flushes completely on branch misprediction.

---
 rtl/lsu_reservation_station_if.sv | 41 ++++
 rtl/lsu_reservation_station.sv | 120 ++++++++++++
 2 files changed

// File: rtl/lsu_reservation_station_if.sv
// lsu_reservation_station_if: dispatch, CDB snoop, mis-predict flush and load/store issue signals of the LSU reservation station.
interface lsu_reservation_station_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int OP_W  = 4
);
  logic             mis_pred;
  logic             disp_valid;
  logic [OP_W-1:0]  disp_op;
  logic [TAG_W-1:0] disp_rob;
  logic             disp_v1;
  logic             disp_v2;
  logic [XLEN-1:0]  disp_opnd1;
  logic [XLEN-1:0]  disp_opnd2;
  logic [XLEN-1:0]  disp_offset;
  logic             full;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             ld_valid;
  logic             ld_ready;
  logic [XLEN-1:0]  ld_addr;
  logic [2:0]       ld_width;
  logic [TAG_W-1:0] ld_rob;
  logic             st_valid;
  logic             st_ready;
  logic [XLEN-1:0]  st_addr;
  logic [XLEN-1:0]  st_data;
  logic [2:0]       st_width;
  logic [TAG_W-1:0] st_rob;
  modport master (
    output mis_pred, disp_valid, disp_op, disp_rob, disp_v1, disp_v2, disp_opnd1, disp_opnd2, disp_offset,
           cdb_valid, cdb_tag, cdb_value, ld_ready, st_ready,
    input  full, ld_valid, ld_addr, ld_width, ld_rob, st_valid, st_addr, st_data, st_width, st_rob
  );
  modport slave (
    input  mis_pred, disp_valid, disp_op, disp_rob, disp_v1, disp_v2, disp_opnd1, disp_opnd2, disp_offset,
           cdb_valid, cdb_tag, cdb_value, ld_ready, st_ready,
    output full, ld_valid, ld_addr, ld_width, ld_rob, st_valid, st_addr, st_data, st_width, st_rob
  );
endinterface

// File: rtl/lsu_reservation_station.sv
// lsu_reservation_station: age-ordered load/store reservation station with CDB wakeup and flush.
// Define LSRS_MEM_ORDER_EN to hold loads behind older stores and issue stores strictly in age order.
module lsu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int OP_W  = 4
) (
  input logic clk,
  input logic reset,
  lsu_reservation_station_if.slave rs
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] r_valid, r_v1, r_v2;
  logic [OP_W-1:0]  r_op  [DEPTH];
  logic [TAG_W-1:0] r_rob [DEPTH];
  logic [XLEN-1:0]  r_o1  [DEPTH];
  logic [XLEN-1:0]  r_o2  [DEPTH];
  logic [XLEN-1:0]  r_off [DEPTH];
  // r_older[i][j] set means entry j was dispatched before entry i
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_ld_lock, r_st_lock;
  logic [IW-1:0]    r_ld_idx, r_st_idx;
  logic [DEPTH-1:0] w_st_held, w_ld_rdy, w_st_rdy;
  logic             w_ld_any, w_st_any, w_ld_v, w_st_v, w_ld_fire, w_st_fire, w_disp, w_byp1, w_byp2;
  logic [IW-1:0]    w_ld_sel, w_st_sel, w_ld_idx, w_st_idx, w_free;
  always_comb begin
    w_st_held = '0;
    w_ld_rdy  = '0;
    w_st_rdy  = '0;
    for (int i = 0; i < DEPTH; i++) w_st_held[i] = r_valid[i] && r_op[i][OP_W-1];
    for (int i = 0; i < DEPTH; i++) begin
`ifdef LSRS_MEM_ORDER_EN
      w_ld_rdy[i] = r_valid[i] && !r_op[i][OP_W-1] && r_v1[i] && r_v2[i] && !(|(r_older[i] & w_st_held));
      w_st_rdy[i] = w_st_held[i] && r_v1[i] && r_v2[i] && !(|(r_older[i] & w_st_held));
`else
      w_ld_rdy[i] = r_valid[i] && !r_op[i][OP_W-1] && r_v1[i] && r_v2[i];
      w_st_rdy[i] = w_st_held[i] && r_v1[i] && r_v2[i];
`endif
    end
  end
  always_comb begin
    w_ld_any = 1'b0;
    w_st_any = 1'b0;
    w_ld_sel = '0;
    w_st_sel = '0;
    w_free   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ld_rdy[i] && !(|(r_older[i] & w_ld_rdy))) begin
        w_ld_any = 1'b1;
        w_ld_sel = IW'(i);
      end
      if (w_st_rdy[i] && !(|(r_older[i] & w_st_rdy))) begin
        w_st_any = 1'b1;
        w_st_sel = IW'(i);
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) w_free = !r_valid[i] ? IW'(i) : w_free;
  end
  // an offered op stays locked until accepted, so a late-woken older op cannot pre-empt it
  assign w_ld_idx  = r_ld_lock ? r_ld_idx : w_ld_sel;
  assign w_st_idx  = r_st_lock ? r_st_idx : w_st_sel;
  assign w_ld_v    = !rs.mis_pred && (r_ld_lock || w_ld_any);
  assign w_st_v    = !rs.mis_pred && (r_st_lock || w_st_any);
  assign w_ld_fire = w_ld_v && rs.ld_ready;
  assign w_st_fire = w_st_v && rs.st_ready;
  assign w_disp    = rs.disp_valid && !rs.full && !rs.mis_pred;
  assign w_byp1    = rs.cdb_valid && !rs.disp_v1 && rs.disp_opnd1[TAG_W-1:0] == rs.cdb_tag;
  assign w_byp2    = rs.cdb_valid && !rs.disp_v2 && rs.disp_opnd2[TAG_W-1:0] == rs.cdb_tag;
  assign rs.full     = r_count == CW'(DEPTH);
  assign rs.ld_valid = w_ld_v;
  assign rs.ld_addr  = r_o1[w_ld_idx] + r_off[w_ld_idx];
  assign rs.ld_width = r_op[w_ld_idx][2:0];
  assign rs.ld_rob   = r_rob[w_ld_idx];
  assign rs.st_valid = w_st_v;
  assign rs.st_addr  = r_o1[w_st_idx] + r_off[w_st_idx];
  assign rs.st_data  = r_o2[w_st_idx];
  assign rs.st_width = r_op[w_st_idx][2:0];
  assign rs.st_rob   = r_rob[w_st_idx];
  always_ff @(posedge clk) begin
    if (reset || rs.mis_pred) begin
      r_valid   <= '0;
      r_count   <= '0;
      r_ld_lock <= 1'b0;
      r_st_lock <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rs.cdb_valid && r_valid[i] && !r_v1[i] && r_o1[i][TAG_W-1:0] == rs.cdb_tag) begin
          r_o1[i] <= rs.cdb_value;
          r_v1[i] <= 1'b1;
        end
        if (rs.cdb_valid && r_valid[i] && !r_v2[i] && r_o2[i][TAG_W-1:0] == rs.cdb_tag) begin
          r_o2[i] <= rs.cdb_value;
          r_v2[i] <= 1'b1;
        end
      end
      if (w_ld_fire) r_valid[w_ld_idx] <= 1'b0;
      if (w_st_fire) r_valid[w_st_idx] <= 1'b0;
      if (w_disp) begin
        r_valid[w_free] <= 1'b1;
        r_op[w_free]    <= rs.disp_op;
        r_rob[w_free]   <= rs.disp_rob;
        r_off[w_free]   <= rs.disp_offset;
        r_v1[w_free]    <= rs.disp_v1 || w_byp1;
        r_v2[w_free]    <= rs.disp_v2 || w_byp2;
        r_o1[w_free]    <= w_byp1 ? rs.cdb_value : rs.disp_opnd1;
        r_o2[w_free]    <= w_byp2 ? rs.cdb_value : rs.disp_opnd2;
        r_older[w_free] <= r_valid;
        for (int j = 0; j < DEPTH; j++) r_older[j][w_free] <= 1'b0;
      end
      r_count   <= r_count + CW'(w_disp) - CW'(w_ld_fire) - CW'(w_st_fire);
      r_ld_lock <= w_ld_v && !rs.ld_ready;
      r_st_lock <= w_st_v && !rs.st_ready;
      r_ld_idx  <= w_ld_idx;
      r_st_idx  <= w_st_idx;
    end
  end
endmodule
